// File: rtl/cim_seq_pkg.sv
// Shared types and constants for the CIM GeMV sequencer.
package cim_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_ACC   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam int CIM_NUM_ROWS    = 8;
    localparam int CIM_GROUP_BYTES = 8;
    localparam int CIM_COLS        = 128;

    // Saturating 32-bit increment used by the performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/cim_seq_drain.sv
// Result drain index: steps through the macro's output rows on each valid/ready handshake.
module cim_seq_drain
    import cim_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       res_ready,
    output logic [2:0] idx,
    output logic       last_hs
);

    logic [2:0] idx_q;
    logic [2:0] idx_d;

    // Next index: advance only on handshake; wraps to 0 after the last row.
    always_comb begin
        idx_d = idx_q;
        if (active && res_ready) begin
            idx_d = idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 3'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx     = idx_q;
    assign last_hs = active && res_ready && (idx_q == 3'(CIM_NUM_ROWS - 1));

endmodule

// File: rtl/cim_gemm_sequencer.sv
// GeMV sequencer for one Basic_GeMM_CIM macro: clear, stream input groups, drain 8 rows.
// Optional CIM_SEQ_PERF_EN adds saturating ACC-cycle and drain-stall counters.
module cim_gemm_sequencer
    import cim_seq_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int IBUF_AW = 8,
    parameter int COL_AW  = 7,
    parameter int MEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COL_AW-1:0]  cmd_wbase,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [IBUF_AW-1:0] cmd_ibase,
    input  logic               host_wr_valid,
    output logic               host_wr_ready,
    input  logic [MEM_AW-1:0]  host_wr_addr,
    input  logic [31:0]        host_wr_data,
    output logic               in_req,
    output logic [IBUF_AW-1:0] in_addr,
    input  logic [31:0]        in_rdata,
    output logic               cim_cs,
    output logic               cim_write,
    output logic               cim_en,
    output logic               cim_psum,
    output logic               cim_rst_out,
    output logic [3:0]         cim_oreg,
    output logic [31:0]        cim_addr,
    output logic [31:0]        cim_wdata,
    input  logic [31:0]        cim_rdata,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2:0]         res_idx,
    output logic [31:0]        res_data,
    output logic               busy,
    output logic               done
`ifdef CIM_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_acc_cycles,
    output logic [31:0]        perf_stall_cycles
`endif
);

    state_e             state_q, state_d;
    logic [COL_AW-1:0]  col_q, col_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IBUF_AW-1:0] ibase_q, ibase_d;
    logic [LEN_W-1:0]   issue_q, issue_d;
    logic [LEN_W-1:0]   grp_q, grp_d;
    logic               armed_q, armed_d;
    logic               done_q, done_d;
    logic               drain_active_s;
    logic               last_hs_s;
    logic [2:0]         drain_idx_s;

    cim_seq_drain u_drain (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (drain_active_s),
        .res_ready (res_ready),
        .idx       (drain_idx_s),
        .last_hs   (last_hs_s)
    );

    // Next-state and macro/handshake outputs; everything idles at 0 unless a state drives it.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        len_d          = len_q;
        ibase_d        = ibase_q;
        issue_d        = issue_q;
        grp_d          = grp_q;
        armed_d        = 1'b1;
        done_d         = last_hs_s;
        cmd_ready      = 1'b0;
        host_wr_ready  = 1'b0;
        in_req         = 1'b0;
        in_addr        = '0;
        cim_cs         = 1'b0;
        cim_write      = 1'b0;
        cim_en         = 1'b0;
        cim_psum       = 1'b0;
        cim_rst_out    = 1'b0;
        cim_oreg       = 4'd0;
        cim_addr       = 32'd0;
        cim_wdata      = 32'd0;
        res_valid      = 1'b0;
        res_idx        = 3'd0;
        res_data       = 32'd0;
        drain_active_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // armed_q keeps the handshakes low until the first clock after reset
                if (armed_q && host_wr_valid) begin
                    host_wr_ready = 1'b1;
                    cim_cs        = 1'b1;
                    cim_write     = 1'b1;
                    cim_addr      = {{(32 - MEM_AW){1'b0}}, host_wr_addr};
                    cim_wdata     = host_wr_data;
                end else if (armed_q) begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        col_d   = cmd_wbase;
                        len_d   = cmd_len;
                        ibase_d = cmd_ibase;
                        issue_d = '0;
                        grp_d   = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cim_cs      = 1'b1;
                cim_en      = 1'b1;
                cim_rst_out = 1'b1;
                if (len_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                in_req  = 1'b1;
                in_addr = ibase_q;
                issue_d = LEN_W'(1);
                state_d = ST_ACC;
            end
            ST_ACC: begin
                cim_cs    = 1'b1;
                cim_en    = 1'b1;
                cim_psum  = 1'b1;
                cim_addr  = {{(32 - COL_AW){1'b0}}, col_q};
                cim_wdata = in_rdata;
                col_d     = col_q + COL_AW'(CIM_GROUP_BYTES);
                // prefetch the next group so one group lands every cycle
                if (issue_q < len_q) begin
                    in_req  = 1'b1;
                    in_addr = ibase_q + IBUF_AW'(issue_q);
                    issue_d = issue_q + LEN_W'(1);
                end else begin
                    issue_d = issue_q;
                end
                if (grp_q == len_q - LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    grp_d = grp_q + LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                cim_en         = 1'b1;
                cim_oreg       = {1'b0, drain_idx_s};
                res_valid      = 1'b1;
                res_idx        = drain_idx_s;
                res_data       = cim_rdata;
                drain_active_s = 1'b1;
                if (last_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            len_q   <= '0;
            ibase_q <= '0;
            issue_q <= '0;
            grp_q   <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            len_q   <= len_d;
            ibase_q <= ibase_d;
            issue_q <= issue_d;
            grp_q   <= grp_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

`ifdef CIM_SEQ_PERF_EN
    logic [31:0] acc_cyc_q, acc_cyc_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;

    // Saturating counters for ACC occupancy and backpressured drain cycles.
    always_comb begin
        acc_cyc_d   = acc_cyc_q;
        stall_cyc_d = stall_cyc_q;
        if (state_q == ST_ACC) begin
            acc_cyc_d = sat_inc32(acc_cyc_q);
        end else begin
            acc_cyc_d = acc_cyc_q;
        end
        if ((state_q == ST_DRAIN) && !res_ready) begin
            stall_cyc_d = sat_inc32(stall_cyc_q);
        end else begin
            stall_cyc_d = stall_cyc_q;
        end
    end

    // Counter registers; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cyc_q   <= 32'd0;
            stall_cyc_q <= 32'd0;
        end else begin
            acc_cyc_q   <= acc_cyc_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign perf_acc_cycles   = acc_cyc_q;
    assign perf_stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_cim_gemm_sequencer.sv
// Scoreboard bench for cim_gemm_sequencer with behavioural models of the input buffer and CIM macro.
module tb_cim_gemm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_wbase = 7'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [7:0]  cmd_ibase = 8'd0;
    logic        host_wr_valid = 1'b0;
    logic        host_wr_ready;
    logic [9:0]  host_wr_addr = 10'd0;
    logic [31:0] host_wr_data = 32'd0;
    logic        in_req;
    logic [7:0]  in_addr;
    logic [31:0] in_rdata = 32'd0;
    logic        cim_cs, cim_write, cim_en, cim_psum, cim_rst_out;
    logic [3:0]  cim_oreg;
    logic [31:0] cim_addr, cim_wdata, cim_rdata;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [2:0]  res_idx;
    logic [31:0] res_data;
    logic        busy, done;
`ifdef CIM_SEQ_PERF_EN
    logic [31:0] perf_acc_cycles, perf_stall_cycles;
`endif

    cim_gemm_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wbase(cmd_wbase),
        .cmd_len(cmd_len), .cmd_ibase(cmd_ibase),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .in_req(in_req), .in_addr(in_addr), .in_rdata(in_rdata),
        .cim_cs(cim_cs), .cim_write(cim_write), .cim_en(cim_en), .cim_psum(cim_psum),
        .cim_rst_out(cim_rst_out), .cim_oreg(cim_oreg), .cim_addr(cim_addr),
        .cim_wdata(cim_wdata), .cim_rdata(cim_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
        .busy(busy), .done(done)
`ifdef CIM_SEQ_PERF_EN
        , .perf_acc_cycles(perf_acc_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int inreq_cnt = 0;
    logic [34:0] sb_q[$];      // {idx[2:0], data[31:0]}
    logic [6:0]  col_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Input buffer: every word holds eight 4-bit inputs of value 8, one-cycle read latency.
    always @(posedge clk) begin
        if (in_req) begin
            in_rdata  <= 32'h8888_8888 ^ {24'd0, in_addr & 8'd0};
            inreq_cnt <= inreq_cnt + 1;
        end else begin
            in_rdata <= 32'd0;
        end
    end

    // Macro model: 8 rows x 128 byte columns; row r at column c uses weights c..c+7.
    // Each group adds (sum of unsigned input nibble * signed weight byte) >>> 9.
    logic [7:0]         wmem [0:1023];
    logic signed [31:0] acc_m [0:7];
    initial begin
        for (int i = 0; i < 1024; i++) wmem[i] = 8'd0;
        for (int i = 0; i < 8; i++) acc_m[i] = 32'sd0;
    end
    assign cim_rdata = acc_m[cim_oreg[2:0]];

    always @(posedge clk) begin
        if (cim_cs && cim_write) begin
            for (int b = 0; b < 4; b++)
                wmem[(cim_addr[9:0] + 10'(b)) & 10'h3FF] <= cim_wdata[31 - 8*b -: 8];
        end else if (cim_cs && cim_en && cim_rst_out) begin
            for (int r = 0; r < 8; r++) acc_m[r] <= 32'sd0;
        end else if (cim_cs && cim_en && cim_psum) begin
            col_log.push_back(cim_addr[6:0]);
            for (int r = 0; r < 8; r++) begin
                int s;
                s = 0;
                for (int j = 0; j < 8; j++) begin
                    int c;
                    c = (int'(cim_addr[6:0]) + j) % 128;
                    s += int'(cim_wdata[4*j +: 4]) * int'($signed(wmem[r*128 + c]));
                end
                acc_m[r] <= acc_m[r] + (s >>> 9);
            end
        end
    end

    // Monitor: pops the scoreboard on each result handshake; checks index hold under backpressure.
    logic       hold_pend = 1'b0;
    logic [2:0] hold_idx = 3'd0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && res_valid) begin
            if (hold_pend) check("idx_hold", {29'd0, res_idx}, {29'd0, hold_idx});
            if (res_ready) begin
                hold_pend = 1'b0;
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    logic [34:0] e;
                    e = sb_q.pop_front();
                    check("res_idx", {29'd0, res_idx}, {29'd0, e[34:32]});
                    check("res_data", res_data, e[31:0]);
                end
            end else begin
                hold_pend = 1'b1;
                hold_idx  = res_idx;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic push_exp(input logic [31:0] val);
        for (int i = 0; i < 8; i++) sb_q.push_back({3'(i), val});
    endtask

    task automatic host_write(input logic [9:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = host_wr_ready;
        end
        if (!ok) check("host_wr_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        host_wr_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [6:0] wb, input logic [7:0] len, input logic [7:0] ib);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_wbase = wb; cmd_len = len; cmd_ibase = ib;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = cmd_ready;
        end
        if (!ok) check("cmd_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = (done_cnt > start);
        end
        if (!ok) check({name, "_done_timeout"}, 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_once"}, 32'(done_cnt - start), 32'd1);
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic fill_weights(input int col0, input int ncols, input logic [31:0] d);
        for (int r = 0; r < 8; r++)
            for (int c = col0; c < col0 + ncols; c += 4)
                host_write(10'(r*128 + c), d);
    endtask

    initial begin
        int st;
        logic [3:0] pat;
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [3:0] pat;
        #1;
        check("reset_outputs", {26'd0, cmd_ready, host_wr_ready, busy, res_valid, cim_cs, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: len=2 from column 0
        fill_weights(0, 16, 32'h4040_4040);
        st = done_cnt; inreq_cnt = 0;
        push_exp(32'd16);
        send_cmd(7'd0, 8'd2, 8'd0);
        wait_done(st, "t1");
        check("t1_inreq", 32'(inreq_cnt), 32'd2);

        // 2: len=1
        st = done_cnt;
        push_exp(32'd8);
        send_cmd(7'd0, 8'd1, 8'd5);
        wait_done(st, "t2");

        // 3: len=0 gives zeros and never reads the input buffer
        st = done_cnt; inreq_cnt = 0;
        push_exp(32'd0);
        send_cmd(7'd3, 8'd0, 8'd0);
        wait_done(st, "t3");
        check("t3_inreq", 32'(inreq_cnt), 32'd0);

        // 4: column wrap 120 -> 0
        fill_weights(8, 8, 32'h0000_0000);
        fill_weights(120, 8, 32'h4040_4040);
        st = done_cnt; col_log.delete();
        push_exp(32'd16);
        send_cmd(7'd120, 8'd2, 8'd250);
        wait_done(st, "t4");
        check("t4_ncols", 32'(col_log.size()), 32'd2);
        if (col_log.size() == 2) begin
            check("t4_col0", {25'd0, col_log[0]}, 32'd120);
            check("t4_col1", {25'd0, col_log[1]}, 32'd0);
        end

        // 5: backpressure pattern 1-0-0-1
        st = done_cnt; pat = 4'b1001;
        push_exp(32'd8);
        send_cmd(7'd0, 8'd1, 8'd0);
        for (int i = 0; i < 200 && done_cnt == st; i++) begin
            res_ready = pat[i % 4];
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        wait_done(st, "t5");

        // 6a: host write and command together; write wins, command next cycle
        st = done_cnt;
        host_wr_valid = 1'b1; host_wr_addr = 10'd64; host_wr_data = 32'd0;
        cmd_valid = 1'b1; cmd_wbase = 7'd0; cmd_len = 8'd1; cmd_ibase = 8'd0;
        @(negedge clk);
        check("t6_wr_ready", {31'd0, host_wr_ready}, 32'd1);
        check("t6_cmd_blocked", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        host_wr_valid = 1'b0;
        @(negedge clk);
        check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        push_exp(32'd8);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(st, "t6a");

        // 6b: reset in the middle of ACC, then a clean len=1 command
        st = done_cnt;
        send_cmd(7'd0, 8'd20, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_in_acc", {31'd0, cim_psum}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_busy", {31'd0, busy}, 32'd0);
        check("t6_reset_outs", {27'd0, cim_cs, cim_psum, in_req, res_valid, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        st = done_cnt;
        push_exp(32'd8);
        send_cmd(7'd0, 8'd1, 8'd0);
        wait_done(st, "t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
